// File: rtl/approx_adder_pkg.sv
// Shared types and helpers for the approximate-adder error sweep.
// Holds the controller state encoding, the approximate cell and the counter width.
package approx_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // Sweep index covers both operands, so it is twice the operand width.
  function automatic int unsigned cnt_w(input int unsigned w);
    return 2 * w;
  endfunction

  // Returns {cout, s}; x = a bit, y = b bit, z = carry in.
  function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic z);
    logic s;
    s = (~x & (y | z)) | (x & y & z);
    return {x, s};
  endfunction

endpackage

// File: rtl/approx_rc_adder.sv
// Combinational ripple-carry adder: K approximate LSB cells followed by exact
// full adders, producing a W+1-bit unsigned sum with carry-in fixed at 0.
module approx_rc_adder
  import approx_adder_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  logic [W:0]   c;
  logic [W-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    if (i < K) begin : g_apx
      assign {c[i+1], s[i]} = approx_cell(a[i], b[i], c[i]);
    end else begin : g_ex
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign sum = {c[W], s};

endmodule

// File: rtl/approx_adder_err_sweep.sv
// Exhaustive error sweep of approx_rc_adder against an exact adder: reports
// max |approx - exact|, the first operand pair reaching it, and the mismatch count.
module approx_adder_err_sweep
  import approx_adder_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [W:0]     max_err,
  output logic [W-1:0]   max_a,
  output logic [W-1:0]   max_b,
  output logic [2*W:0]   err_count
);

  localparam int unsigned CW = cnt_w(W);

  state_t        state;
  logic [CW-1:0] idx;
  logic [W-1:0]  cur_a;
  logic [W-1:0]  cur_b;
  logic [W:0]    apx_sum;
  logic [W:0]    ex_sum;
  logic          accept;

  logic          s1_valid;
  logic [W:0]    s1_apx;
  logic [W:0]    s1_ex;
  logic [W-1:0]  s1_a;
  logic [W-1:0]  s1_b;
  logic [W:0]    err;

  always_comb begin
    cur_a  = idx[W-1:0];
    cur_b  = idx[CW-1:W];
    ex_sum = {1'b0, cur_a} + {1'b0, cur_b};
    accept = start && ((state == IDLE) || (state == DONE));
  end

  approx_rc_adder #(
    .W(W),
    .K(K)
  ) u_adder (
    .a  (cur_a),
    .b  (cur_b),
    .sum(apx_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
          end
        end
        RUN: begin
          idx <= idx + CW'(1);
          if (idx == '1) state <= DRAIN;
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          done <= 1'b0;
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_apx   <= '0;
      s1_ex    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= (state == RUN);
      s1_apx   <= apx_sum;
      s1_ex    <= ex_sum;
      s1_a     <= cur_a;
      s1_b     <= cur_b;
    end
  end

  always_comb begin
    err = (s1_apx >= s1_ex) ? (s1_apx - s1_ex) : (s1_ex - s1_apx);
  end

  // Stage 1 is never valid while a start can be accepted, so clearing wins cleanly.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_err   <= '0;
      max_a     <= '0;
      max_b     <= '0;
      err_count <= '0;
    end else if (s1_valid) begin
      if (err > max_err) begin
        max_err <= err;
        max_a   <= s1_a;
        max_b   <= s1_b;
      end
      if (err != '0) err_count <= err_count + (2*W+1)'(1);
    end
  end

endmodule

// File: tb/tb_approx_adder_err_sweep.sv
// Bench for approx_adder_err_sweep: four parameterisations checked against an
// arithmetic model of the cell equations, plus timing, reset and start handling.
module tb_approx_adder_err_sweep;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic start_v [4];
  logic rst_v   [4];
  int   busy_v  [4];
  int   done_v  [4];
  int   me_v    [4];
  int   ma_v    [4];
  int   mb_v    [4];
  int   ec_v    [4];

  logic busy0, done0, busy1, done1, busy2, done2, busy3, done3;
  logic [4:0] me0, me1;
  logic [3:0] ma0, mb0, ma1, mb1;
  logic [8:0] ec0, ec1;
  logic [2:0] me2, me3;
  logic [1:0] ma2, mb2, ma3, mb3;
  logic [4:0] ec2, ec3;

  approx_adder_err_sweep #(.W(4), .K(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy0), .done(done0),
    .max_err(me0), .max_a(ma0), .max_b(mb0), .err_count(ec0));
  approx_adder_err_sweep #(.W(4), .K(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy1), .done(done1),
    .max_err(me1), .max_a(ma1), .max_b(mb1), .err_count(ec1));
  approx_adder_err_sweep #(.W(2), .K(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy2), .done(done2),
    .max_err(me2), .max_a(ma2), .max_b(mb2), .err_count(ec2));
  approx_adder_err_sweep #(.W(2), .K(1)) u3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .busy(busy3), .done(done3),
    .max_err(me3), .max_a(ma3), .max_b(mb3), .err_count(ec3));

  assign busy_v[0] = int'(busy0);  assign done_v[0] = int'(done0);
  assign busy_v[1] = int'(busy1);  assign done_v[1] = int'(done1);
  assign busy_v[2] = int'(busy2);  assign done_v[2] = int'(done2);
  assign busy_v[3] = int'(busy3);  assign done_v[3] = int'(done3);
  assign me_v[0] = int'(me0);  assign ma_v[0] = int'(ma0);  assign mb_v[0] = int'(mb0);  assign ec_v[0] = int'(ec0);
  assign me_v[1] = int'(me1);  assign ma_v[1] = int'(ma1);  assign mb_v[1] = int'(mb1);  assign ec_v[1] = int'(ec1);
  assign me_v[2] = int'(me2);  assign ma_v[2] = int'(ma2);  assign mb_v[2] = int'(mb2);  assign ec_v[2] = int'(ec2);
  assign me_v[3] = int'(me3);  assign ma_v[3] = int'(ma3);  assign mb_v[3] = int'(mb3);  assign ec_v[3] = int'(ec3);

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Exhaustive model in sweep order, straight from the cell equations.
  task automatic ref_sweep(input int w, input int k, output int me, output int ma,
                           output int mb, output int ec);
    int a, b, c, s, x, y, z, apx, ex, e;
    me = 0; ma = 0; mb = 0; ec = 0;
    for (int idx = 0; idx < (1 << (2 * w)); idx++) begin
      a = idx % (1 << w);
      b = idx / (1 << w);
      c = 0;
      apx = 0;
      for (int i = 0; i < w; i++) begin
        x = (a >> i) & 1;
        y = (b >> i) & 1;
        z = c;
        if (i < k) begin
          s = ((x == 0 && (y == 1 || z == 1)) || (x == 1 && y == 1 && z == 1)) ? 1 : 0;
          c = x;
        end else begin
          s = x ^ y ^ z;
          c = (x + y + z >= 2) ? 1 : 0;
        end
        apx += s << i;
      end
      apx += c << w;
      ex = a + b;
      e = (apx > ex) ? apx - ex : ex - apx;
      if (e > me) begin
        me = e; ma = a; mb = b;
      end
      if (e != 0) ec++;
    end
  endtask

  task automatic check_results(input int s, input string tag, input int w, input int k);
    int me, ma, mb, ec;
    ref_sweep(w, k, me, ma, mb, ec);
    check({tag, "_max_err"}, me_v[s], me);
    check({tag, "_max_a"}, ma_v[s], ma);
    check({tag, "_max_b"}, mb_v[s], mb);
    check({tag, "_err_count"}, ec_v[s], ec);
  endtask

  // Called just after the start edge; k = edges until done is seen.
  task automatic wait_done(input int s, input int limit, output int k, output int bh);
    k = 0;
    bh = 0;
    while (done_v[s] == 0 && k < limit) begin
      if (busy_v[s] != 0) bh++;
      tick;
      k++;
    end
  endtask

  initial begin
    int k, bh, dn;
    for (int i = 0; i < 4; i++) begin
      rst_v[i] = 1'b1;
      start_v[i] = 1'b0;
    end
    tick;
    tick;
    for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst%0d_busy", i), busy_v[i], 0);
      check($sformatf("rst%0d_done", i), done_v[i], 0);
      check($sformatf("rst%0d_max_err", i), me_v[i], 0);
      check($sformatf("rst%0d_err_count", i), ec_v[i], 0);
    end

    // W=4 K=0: exact adder, timing of busy and done.
    repeat ($urandom_range(1, 5)) tick;
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    wait_done(0, 1000, k, bh);
    check("k0_done_cycle", k + 1, 258);
    check("k0_busy_cycles", bh, 257);
    check_results(0, "k0", 4, 0);
    check("k0_max_a_zero", ma_v[0], 0);
    tick;
    check("k0_done_pulse", done_v[0], 0);
    check("k0_idle_busy", busy_v[0], 0);

    // W=4 K=1 with random start pulses while busy, including the DRAIN cycle.
    repeat ($urandom_range(1, 5)) tick;
    start_v[1] = 1'b1;
    tick;
    start_v[1] = 1'b0;
    k = 0;
    while (done_v[1] == 0 && k < 1000) begin
      start_v[1] = (busy_v[1] != 0) && ($urandom_range(0, 3) == 0 || k == 256);
      tick;
      start_v[1] = 1'b0;
      k++;
    end
    check("k1_done_cycle", k + 1, 258);
    check_results(1, "k1", 4, 1);
    check("k1_spec_err_count", ec_v[1], 64);
    tick;
    check("k1_done_pulse", done_v[1], 0);

    // Reset 100 cycles into RUN aborts without a done pulse.
    start_v[1] = 1'b1;
    tick;
    start_v[1] = 1'b0;
    repeat (100) tick;
    rst_v[1] = 1'b1;
    tick;
    rst_v[1] = 1'b0;
    check("abort_busy", busy_v[1], 0);
    check("abort_done", done_v[1], 0);
    check("abort_max_err", me_v[1], 0);
    check("abort_max_a", ma_v[1], 0);
    check("abort_err_count", ec_v[1], 0);
    dn = 0;
    repeat (300) begin
      tick;
      if (done_v[1] != 0) dn++;
    end
    check("abort_no_done", dn, 0);

    start_v[1] = 1'b1;
    tick;
    start_v[1] = 1'b0;
    wait_done(1, 1000, k, bh);
    check("fresh_done_cycle", k + 1, 258);
    check_results(1, "fresh", 4, 1);

    // Start in the done cycle: results clear and RUN follows directly.
    start_v[1] = 1'b1;
    tick;
    start_v[1] = 1'b0;
    check("restart_busy", busy_v[1], 1);
    check("restart_done", done_v[1], 0);
    check("restart_max_err", me_v[1], 0);
    check("restart_err_count", ec_v[1], 0);
    wait_done(1, 1000, k, bh);
    check("restart_done_cycle", k + 1, 258);
    check_results(1, "restart", 4, 1);

    // W=2 K=2: fully approximate adder.
    repeat ($urandom_range(1, 5)) tick;
    start_v[2] = 1'b1;
    tick;
    start_v[2] = 1'b0;
    wait_done(2, 200, k, bh);
    check("k2_done_cycle", k + 1, 18);
    check_results(2, "k2", 2, 2);

    // W=2 K=1 with start held: back-to-back sweeps every 18 cycles.
    repeat ($urandom_range(1, 5)) tick;
    start_v[3] = 1'b1;
    tick;
    for (int r = 0; r < 3; r++) begin
      wait_done(3, 200, k, bh);
      check($sformatf("b2b%0d_done_cycle", r), k + 1, 18);
      check_results(3, $sformatf("b2b%0d", r), 2, 1);
      if (r < 2) begin
        tick;
        check($sformatf("b2b%0d_rerun_busy", r), busy_v[3], 1);
        check($sformatf("b2b%0d_rerun_clr", r), ec_v[3], 0);
      end
    end
    start_v[3] = 1'b0;
    repeat (4) tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
